// File: rtl/psum_su_pkg.sv
// Shared types, widths and slicing helpers for the partial-sum reducer.
package psum_su_pkg;

  localparam int ROW                = 16;
  localparam int COL                = 16;
  localparam int OUT_BITWIDTH       = 16;
  localparam int PSUM_ADDR_BITWIDTH = 2;
  localparam int PSUM_DEPTH         = 4;
  localparam int ACC_BITWIDTH       = 32;

  localparam int PSUM_W  = OUT_BITWIDTH * ROW * COL;
  localparam int LANES_W = ACC_BITWIDTH * COL;

  localparam logic [PSUM_ADDR_BITWIDTH-1:0] ADDR_LAST = PSUM_ADDR_BITWIDTH'(PSUM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_FIN   = 3'd3,
    S_OUT   = 3'd4
  } su_state_e;

  // PE (r,c) psum out of the flattened PE-array bus.
  function automatic logic [OUT_BITWIDTH-1:0] pe_slice(input logic [PSUM_W-1:0] v,
                                                       input int r, input int c);
    return v[(r*COL+c)*OUT_BITWIDTH +: OUT_BITWIDTH];
  endfunction

  // Accumulator lane c out of a flattened lane bus.
  function automatic logic [ACC_BITWIDTH-1:0] lane_get(input logic [LANES_W-1:0] v,
                                                       input int c);
    return v[c*ACC_BITWIDTH +: ACC_BITWIDTH];
  endfunction

  function automatic logic [ACC_BITWIDTH-1:0] sext_acc(input logic [OUT_BITWIDTH-1:0] x);
    return {{(ACC_BITWIDTH-OUT_BITWIDTH){x[OUT_BITWIDTH-1]}}, x};
  endfunction

endpackage

// File: rtl/psum_su_reducer.sv
// Row reducer: registers the PE psum bus, then sums every column over all rows.
// Sums appear two cycles after the RF address that produced them.
module su_row_reducer
  import psum_su_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PSUM_W-1:0]  psum_i,
  output logic [LANES_W-1:0] col_sum_o
);

  logic [PSUM_W-1:0] psum_q;

  // Input register: captures the RF read data the cycle after the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) psum_q <= '0;
    else        psum_q <= psum_i;
  end

  // Per-column sign-extended sum over all rows, wrapping at accumulator width.
  always_comb begin
    col_sum_o = '0;
    for (int c = 0; c < COL; c++) begin
      for (int r = 0; r < ROW; r++) begin
        col_sum_o[c*ACC_BITWIDTH +: ACC_BITWIDTH] =
          col_sum_o[c*ACC_BITWIDTH +: ACC_BITWIDTH] + sext_acc(pe_slice(psum_q, r, c));
      end
    end
  end

endmodule

// File: rtl/psum_su_adder.sv
// Partial-sum reducer top: sweeps PE psum RFs each round, accumulates column
// sums over a configured number of rounds, then streams them out.
//
// state | meaning
// IDLE  | waiting for pe_psum_finish
// READ  | issuing RF addresses 0..PSUM_DEPTH-1
// DRAIN | reducer pipeline flushing the last two addresses
// FIN   | su_add_finish high until turn_off
// OUT   | streaming acc_buf entries over valid/ready
module psum_su_adder
  import psum_su_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pe_psum_finish,
  input  logic                          turn_off,
  input  logic [7:0]                    acc_rounds,
  input  logic [PSUM_W-1:0]             psum_out,
  output logic [PSUM_ADDR_BITWIDTH-1:0] addr_from_su_adder,
  output logic                          su_add_finish,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES_W-1:0]            out_data,
  output logic                          out_last
);

  su_state_e state_q, state_d;
  logic [PSUM_ADDR_BITWIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [PSUM_ADDR_BITWIDTH-1:0] out_addr_q, out_addr_d;
  logic                          drain_cnt_q, drain_cnt_d;
  logic [7:0]                    round_q, round_d;
  logic [7:0]                    rounds_q, rounds_d;

  // Write-back pipeline tracking which address the reducer output belongs to.
  logic                          v1_q, v2_q;
  logic [PSUM_ADDR_BITWIDTH-1:0] a1_q, a2_q;

  logic [LANES_W-1:0] col_sum;
  logic [LANES_W-1:0] wr_data;
  logic [LANES_W-1:0] acc_buf_q [PSUM_DEPTH];

  su_row_reducer u_reducer (
    .clk       (clk),
    .rst_n     (reset),
    .psum_i    (psum_out),
    .col_sum_o (col_sum)
  );

  // Control state and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      out_addr_q  <= '0;
      drain_cnt_q <= 1'b0;
      round_q     <= '0;
      rounds_q    <= 8'd1;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      out_addr_q  <= out_addr_d;
      drain_cnt_q <= drain_cnt_d;
      round_q     <= round_d;
      rounds_q    <= rounds_d;
    end
  end

  // Next-state logic; round count is only latched at the start of round 0.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    out_addr_d  = out_addr_q;
    drain_cnt_d = drain_cnt_q;
    round_d     = round_q;
    rounds_d    = rounds_q;
    unique case (state_q)
      S_IDLE: begin
        if (pe_psum_finish) begin
          state_d   = S_READ;
          rd_addr_d = '0;
          if (round_q == 8'd0) rounds_d = (acc_rounds == 8'd0) ? 8'd1 : acc_rounds;
        end
      end
      S_READ: begin
        if (rd_addr_q == ADDR_LAST) begin
          rd_addr_d   = '0;
          drain_cnt_d = 1'b1;
          state_d     = S_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + PSUM_ADDR_BITWIDTH'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == 1'b0) state_d = S_FIN;
        else                     drain_cnt_d = drain_cnt_q - 1'b1;
      end
      S_FIN: begin
        if (turn_off) begin
          if (round_q + 8'd1 == rounds_q) begin
            round_d    = '0;
            out_addr_d = '0;
            state_d    = S_OUT;
          end else begin
            round_d = round_q + 8'd1;
            state_d = S_IDLE;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (out_addr_q == ADDR_LAST) begin
            out_addr_d = '0;
            state_d    = S_IDLE;
          end else begin
            out_addr_d = out_addr_q + PSUM_ADDR_BITWIDTH'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Delay the read address by two cycles to line it up with the column sums.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      a1_q <= '0;
      a2_q <= '0;
    end else begin
      v1_q <= (state_q == S_READ);
      a1_q <= rd_addr_q;
      v2_q <= v1_q;
      a2_q <= a1_q;
    end
  end

  // Round 0 overwrites the entry so stale contents never leak into a new result.
  always_comb begin
    wr_data = '0;
    for (int c = 0; c < COL; c++) begin
      wr_data[c*ACC_BITWIDTH +: ACC_BITWIDTH] = (round_q == 8'd0)
        ? lane_get(col_sum, c)
        : lane_get(acc_buf_q[a2_q], c) + lane_get(col_sum, c);
    end
  end

  // Accumulation buffer write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PSUM_DEPTH; i++) acc_buf_q[i] <= '0;
    end else if (v2_q) begin
      acc_buf_q[a2_q] <= wr_data;
    end
  end

  assign addr_from_su_adder = rd_addr_q;
  assign su_add_finish      = (state_q == S_FIN);
  assign out_valid          = (state_q == S_OUT);
  assign out_last           = out_valid && (out_addr_q == ADDR_LAST);
  assign out_data           = acc_buf_q[out_addr_q];

endmodule

// File: tb/tb_psum_su_adder.sv
// Self-checking bench for psum_su_adder: a PE RF model drives psum_out from the
// address, expected beats are queued per round and popped as beats transfer.
module tb_psum_su_adder;
  import psum_su_pkg::*;

  typedef struct packed {
    logic [LANES_W-1:0] data;
    logic               last;
  } beat_t;

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          pe_psum_finish;
  logic                          turn_off;
  logic [7:0]                    acc_rounds;
  logic [PSUM_W-1:0]             psum_out;
  logic [PSUM_ADDR_BITWIDTH-1:0] addr_from_su_adder;
  logic                          su_add_finish;
  logic                          out_valid;
  logic                          out_ready;
  logic [LANES_W-1:0]            out_data;
  logic                          out_last;

  int checks = 0;
  int errors = 0;
  int cur_mode = 0;
  int cur_seed = 0;
  logic [PSUM_ADDR_BITWIDTH-1:0] addr_prev = '0;
  logic [31:0] exp_acc [PSUM_DEPTH][COL];
  beat_t sb_q [$];

  psum_su_adder dut (
    .clk                (clk),
    .reset              (reset),
    .pe_psum_finish     (pe_psum_finish),
    .turn_off           (turn_off),
    .acc_rounds         (acc_rounds),
    .psum_out           (psum_out),
    .addr_from_su_adder (addr_from_su_adder),
    .su_add_finish      (su_add_finish),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_data           (out_data),
    .out_last           (out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pe_val(input int mode, input int seed,
                                         input int r, input int c, input int a);
    case (mode)
      0:       return 16'h0001;
      1:       return 16'hFFFF;
      2:       return 16'(c + 1);
      default: return 16'(((r*37 + c*11 + a*53 + seed*29) % 251) - 125);
    endcase
  endfunction

  // PE RF model: read data appears one cycle after the address.
  always @(negedge clk) begin
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL; c++)
        psum_out[(r*COL+c)*OUT_BITWIDTH +: OUT_BITWIDTH] = pe_val(cur_mode, cur_seed, r, c, int'(addr_prev));
    addr_prev = addr_from_su_adder;
  end

  // Called at a negedge with the DUT idle; returns at the negedge after turn_off.
  task automatic run_round(input int mode, input int seed, input logic [7:0] cfg,
                           input bit first, input bit final_round);
    int sum;
    beat_t b;
    for (int a = 0; a < PSUM_DEPTH; a++) begin
      for (int c = 0; c < COL; c++) begin
        sum = 0;
        for (int r = 0; r < ROW; r++) sum += int'($signed(pe_val(mode, seed, r, c, a)));
        if (first) exp_acc[a][c] = 32'(sum);
        else       exp_acc[a][c] = exp_acc[a][c] + 32'(sum);
      end
    end
    cur_mode       = mode;
    cur_seed       = seed;
    out_ready      = 1'b0;
    acc_rounds     = cfg;
    pe_psum_finish = 1'b1;
    for (int k = 1; k <= PSUM_DEPTH + 3; k++) begin
      @(negedge clk);
      if (k == 1) pe_psum_finish = 1'b0;
      if (k <= PSUM_DEPTH) begin
        checks++;
        if (addr_from_su_adder !== 2'(k - 1)) begin
          errors++;
          $display("FAIL read_addr cycle %0d: got %0d want %0d", k, addr_from_su_adder, k - 1);
        end
      end
      checks++;
      if (su_add_finish !== (k == PSUM_DEPTH + 3)) begin
        errors++;
        $display("FAIL finish_timing cycle %0d: got %b want %b", k, su_add_finish, (k == PSUM_DEPTH + 3));
      end
    end
    turn_off = 1'b1;
    @(negedge clk);
    turn_off = 1'b0;
    checks++;
    if (su_add_finish !== 1'b0) begin
      errors++;
      $display("FAIL finish_drop: got %b want 0", su_add_finish);
    end
    checks++;
    if (out_valid !== final_round) begin
      errors++;
      $display("FAIL valid_after_round: got %b want %b", out_valid, final_round);
    end
    if (final_round) begin
      for (int a = 0; a < PSUM_DEPTH; a++) begin
        for (int c = 0; c < COL; c++) b.data[c*ACC_BITWIDTH +: ACC_BITWIDTH] = exp_acc[a][c];
        b.last = (a == PSUM_DEPTH - 1);
        sb_q.push_back(b);
      end
    end
  endtask

  // Drains the scoreboard; returns at the negedge of the last accepted beat.
  task automatic collect_beats(input bit toggle, input int max_cycles);
    logic [LANES_W-1:0] held;
    bit    stalled;
    int    it;
    beat_t e;
    stalled = 1'b0;
    it      = 0;
    held    = '0;
    while (sb_q.size() > 0) begin
      if (it >= max_cycles) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: got %0d beats pending want 0", sb_q.size());
        sb_q.delete();
        break;
      end
      if (toggle) out_ready = (it % 2 == 0);
      else        out_ready = 1'b1;
      if (stalled) begin
        checks++;
        if (out_data !== held) begin
          errors++;
          $display("FAIL stall_hold: got %h want %h", out_data, held);
        end
      end
      if (out_valid && out_ready) begin
        e = sb_q.pop_front();
        checks++;
        if (out_data !== e.data) begin
          errors++;
          $display("FAIL beat_data: got %h want %h", out_data, e.data);
        end
        checks++;
        if (out_last !== e.last) begin
          errors++;
          $display("FAIL beat_last: got %b want %b", out_last, e.last);
        end
        stalled = 1'b0;
        if (sb_q.size() == 0) break;
      end else begin
        stalled = out_valid;
        held    = out_data;
      end
      @(negedge clk);
      it++;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if ({addr_from_su_adder, su_add_finish, out_valid, out_last} !== '0) begin
      errors++;
      $display("FAIL %s_ctrl: got addr=%0d fin=%b valid=%b last=%b want all 0",
               tag, addr_from_su_adder, su_add_finish, out_valid, out_last);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL %s_data: got %h want 0", tag, out_data);
    end
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    pe_psum_finish = 1'b0;
    turn_off       = 1'b0;
    out_ready      = 1'b0;
    acc_rounds     = 8'd1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("post_reset");
  endtask

  task automatic test_ones();
    run_round(0, 0, 8'd1, 1'b1, 1'b1);
    collect_beats(1'b0, 20);
    @(negedge clk);
  endtask

  task automatic test_neg_ones();
    run_round(1, 0, 8'd1, 1'b1, 1'b1);
    collect_beats(1'b0, 20);
    @(negedge clk);
  endtask

  task automatic test_accumulate();
    // Later-round acc_rounds values must be ignored.
    run_round(2, 0, 8'd3, 1'b1, 1'b0);
    run_round(2, 0, 8'd7, 1'b0, 1'b0);
    run_round(2, 0, 8'd7, 1'b0, 1'b1);
    collect_beats(1'b0, 20);
    @(negedge clk);
  endtask

  task automatic test_back_to_back_stall();
    run_round(3, 1, 8'd1, 1'b1, 1'b1);
    collect_beats(1'b1, 40);
    @(negedge clk);
  endtask

  task automatic test_rounds_zero();
    run_round(3, 2, 8'd0, 1'b1, 1'b1);
    collect_beats(1'b0, 20);
    @(negedge clk);
  endtask

  task automatic test_finish_held();
    run_round(0, 0, 8'd1, 1'b1, 1'b1);
    pe_psum_finish = 1'b1;
    collect_beats(1'b1, 40);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (addr_from_su_adder !== ((k == 3) ? 2'd1 : 2'd0)) begin
        errors++;
        $display("FAIL held_restart cycle %0d: got addr %0d want %0d", k, addr_from_su_adder, (k == 3) ? 1 : 0);
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL held_restart_valid: got %b want 0", out_valid);
    end
    pe_psum_finish = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    run_round(3, 5, 8'd2, 1'b1, 1'b0);
    pe_psum_finish = 1'b1;
    acc_rounds     = 8'd2;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      pe_psum_finish = 1'b0;
    end
    checks++;
    if (addr_from_su_adder !== 2'd2) begin
      errors++;
      $display("FAIL mid_addr: got %0d want 2", addr_from_su_adder);
    end
    reset = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_round(3, 9, 8'd1, 1'b1, 1'b1);
    collect_beats(1'b0, 20);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ones();
    test_neg_ones();
    test_accumulate();
    test_back_to_back_stall();
    test_rounds_zero();
    test_finish_held();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
